// File: rtl/sprite_rom_arbiter_if.sv
// Request/grant, ROM port and tagged-response signals between sprite renderers,
// the shared sprite ROM and sprite_rom_arbiter.
interface sprite_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 2
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_address;
  logic [DATA_W-1:0]       rom_q;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_data;

  // Renderer/ROM side of the block
  modport master (
    output req, addr, rom_q,
    input  gnt, rom_address, rsp_valid, rsp_id, rsp_data
  );

  // Arbiter side
  modport slave (
    input  req, addr, rom_q,
    output gnt, rom_address, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one sprite ROM read port among N_REQ renderers with ID-tagged
// responses. Define SPRITE_ARB_PRIO0_EN to give requester 0 absolute priority.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 2,
  parameter int ROM_LAT = 1
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  sprite_rom_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]                rr_ptr;
  logic [N_REQ-1:0]               rr_req;
  logic                           found_p0;
  logic                           prio_win_p0;
  logic                           xfer_p0;
  logic [ID_W-1:0]                win_id_p0;
  logic [ID_W:0]                  idx_w;
  logic [ADDR_W-1:0]              win_addr_p0;
  logic [N_REQ-1:0]               gnt_p0;

  logic [ADDR_W-1:0]              rom_address_p1;
  logic [ROM_LAT-1:0]             tag_vld_p;
  logic [ROM_LAT-1:0][ID_W-1:0]   tag_id_p;

  logic                           rsp_vld_p2;
  logic [ID_W-1:0]                rsp_id_p2;
  logic [DATA_W-1:0]              rsp_data_p2;

  function automatic logic [ID_W-1:0] ptr_next(input logic [ID_W-1:0] w);
    if (w == ID_W'(N_REQ-1)) return '0;
    return w + 1'b1;
  endfunction

  // Stage p0: combinational arbitration and address select
  always_comb begin
    rr_req      = bus.req;
    found_p0    = 1'b0;
    win_id_p0   = '0;
    idx_w       = '0;
    prio_win_p0 = 1'b0;
`ifdef SPRITE_ARB_PRIO0_EN
    rr_req[0]   = 1'b0;
    prio_win_p0 = bus.req[0];
`endif
    for (int k = 0; k < N_REQ; k++) begin
      idx_w = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx_w >= (ID_W+1)'(N_REQ)) idx_w = idx_w - (ID_W+1)'(N_REQ);
      if (!found_p0 && rr_req[idx_w[ID_W-1:0]]) begin
        found_p0  = 1'b1;
        win_id_p0 = idx_w[ID_W-1:0];
      end
    end
    if (prio_win_p0) begin
      found_p0  = 1'b1;
      win_id_p0 = '0;
    end
    xfer_p0 = found_p0 && !reset;
    gnt_p0  = '0;
    if (xfer_p0) gnt_p0[win_id_p0] = 1'b1;
    win_addr_p0 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id_p0 == ID_W'(i)) win_addr_p0 = bus.addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Stage p1: ROM address register and tag pipe matching the ROM read latency;
  // stage p2: response capture as the oldest tag leaves the pipe
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= '0;
      rom_address_p1 <= '0;
      tag_vld_p      <= '0;
      tag_id_p       <= '0;
      rsp_vld_p2     <= 1'b0;
      rsp_id_p2      <= '0;
      rsp_data_p2    <= '0;
    end else begin
      if (xfer_p0) begin
        rom_address_p1 <= win_addr_p0;
        // A priority grant to requester 0 leaves the rotation where it was
        if (!prio_win_p0) rr_ptr <= ptr_next(win_id_p0);
      end
      tag_vld_p[0] <= xfer_p0;
      tag_id_p[0]  <= win_id_p0;
      for (int s = 1; s < ROM_LAT; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_id_p[s]  <= tag_id_p[s-1];
      end
      rsp_vld_p2 <= tag_vld_p[ROM_LAT-1];
      rsp_id_p2  <= tag_id_p[ROM_LAT-1];
      if (tag_vld_p[ROM_LAT-1]) rsp_data_p2 <= bus.rom_q;
    end
  end

  assign bus.gnt         = gnt_p0;
  assign bus.rom_address = rom_address_p1;
  assign bus.rsp_valid   = rsp_vld_p2;
  assign bus.rsp_id      = rsp_id_p2;
  assign bus.rsp_data    = rsp_data_p2;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: one instance with ROM_LAT=1 and one with ROM_LAT=3,
// sharing stimulus, each fed by a behavioural ROM with matching latency.
module tb_sprite_rom_arbiter;
  localparam int N_REQ  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [DATA_W-1:0]       rom_q1, q3a, q3b, q3c;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sprite_rom_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
  sprite_rom_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

  assign bus1.req   = req;
  assign bus1.addr  = addr;
  assign bus1.rom_q = rom_q1;
  assign bus3.req   = req;
  assign bus3.addr  = addr;
  assign bus3.rom_q = q3c;

  sprite_rom_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1)) dut1 (
    .vga_clk (clk),
    .reset   (reset),
    .bus     (bus1)
  );

  sprite_rom_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(3)) dut3 (
    .vga_clk (clk),
    .reset   (reset),
    .bus     (bus3)
  );

  function automatic logic [DATA_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    s = a + (a >> 3);
    return s[DATA_W-1:0];
  endfunction

  // ROM clocked on the falling edge; the LAT=3 copy adds two rising-edge stages
  always @(negedge clk) begin
    rom_q1 <= rom_val(bus1.rom_address);
    q3a    <= rom_val(bus3.rom_address);
  end
  always @(posedge clk) begin
    q3b <= q3a;
    q3c <= q3b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},      32'(bus1.gnt), 32'd0);
    chk({tag, "_romaddr1"}, 32'(bus1.rom_address), 32'd0);
    chk({tag, "_romaddr3"}, 32'(bus3.rom_address), 32'd0);
    chk({tag, "_vld1"},     32'(bus1.rsp_valid), 32'd0);
    chk({tag, "_vld3"},     32'(bus3.rsp_valid), 32'd0);
    chk({tag, "_id1"},      32'(bus1.rsp_id), 32'd0);
    chk({tag, "_id3"},      32'(bus3.rsp_id), 32'd0);
    chk({tag, "_data1"},    32'(bus1.rsp_data), 32'd0);
    chk({tag, "_data3"},    32'(bus3.rsp_data), 32'd0);
  endtask

  initial begin
    logic [3:0]        exp_gnt [8];
    logic [1:0]        exp_id  [8];
    logic [ADDR_W-1:0] t3_addr [N_REQ];
    logic [1:0]        id1_q [$];
    logic [1:0]        id3_q [$];
    logic [DATA_W-1:0] dat1_q [$];
    logic [DATA_W-1:0] dat3_q [$];
    int                first1;
    int                first3;

    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    t3_addr = '{10'd3, 10'd53, 10'd103, 10'd153};

    reset = 1'b1;
    req   = '0;
    addr  = '0;
    repeat (2) @(negedge clk);
    req = 4'b1111;
    #1;
    chk_zero("por");
    req   = '0;
    reset = 1'b0;

    // Single read of address 37 (ROM[37] = 1)
    @(negedge clk);
    set_addr(0, 10'd37);
    req = 4'b0001;
    #1;
    chk("t2_gnt", 32'(bus1.gnt), 32'(4'b0001));
    @(negedge clk);
    req = '0;
    #1;
    chk("t2_romaddr", 32'(bus1.rom_address), 32'd37);
    chk("t2_gnt_idle", 32'(bus1.gnt), 32'd0);
    chk("t2_vld_early", 32'(bus1.rsp_valid), 32'd0);
    @(negedge clk);
    chk("t2_vld", 32'(bus1.rsp_valid), 32'd1);
    chk("t2_id", 32'(bus1.rsp_id), 32'd0);
    chk("t2_data", 32'(bus1.rsp_data), 32'd1);
    chk("t2_vld3_early", 32'(bus3.rsp_valid), 32'd0);
    @(negedge clk);
    chk("t2_vld_once", 32'(bus1.rsp_valid), 32'd0);
    chk("t2_vld3_early2", 32'(bus3.rsp_valid), 32'd0);
    @(negedge clk);
    chk("t2_vld3", 32'(bus3.rsp_valid), 32'd1);
    chk("t2_id3", 32'(bus3.rsp_id), 32'd0);
    chk("t2_data3", 32'(bus3.rsp_data), 32'd1);

    // Grant requester 3 so the rotation pointer wraps to 0
    @(negedge clk);
    set_addr(3, 10'd5);
    req = 4'b1000;
    #1;
    chk("pre_gnt3", 32'(bus1.gnt), 32'(4'b1000));
    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);

    // All requesters for 8 cycles: strict rotation, responses in grant order
    for (int i = 0; i < N_REQ; i++) set_addr(i, t3_addr[i]);
    first1 = -1;
    first3 = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus1.rsp_valid) begin
        if (first1 < 0) first1 = c;
        id1_q.push_back(bus1.rsp_id);
        dat1_q.push_back(bus1.rsp_data);
      end
      if (bus3.rsp_valid) begin
        if (first3 < 0) first3 = c;
        id3_q.push_back(bus3.rsp_id);
        dat3_q.push_back(bus3.rsp_data);
      end
      req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) chk($sformatf("t3_gnt%0d", c), 32'(bus1.gnt), 32'(exp_gnt[c]));
    end
    chk("t3_first1", 32'(first1), 32'd2);
    chk("t3_first3", 32'(first3), 32'd4);
    chk("t3_cnt1", 32'(id1_q.size()), 32'd8);
    chk("t3_cnt3", 32'(id3_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < id1_q.size()) begin
        chk($sformatf("t3_id1_%0d", k), 32'(id1_q[k]), 32'(exp_id[k]));
        chk($sformatf("t3_dat1_%0d", k), 32'(dat1_q[k]), 32'(rom_val(t3_addr[exp_id[k]])));
      end
      if (k < id3_q.size()) begin
        chk($sformatf("t3_id3_%0d", k), 32'(id3_q[k]), 32'(exp_id[k]));
        chk($sformatf("t3_dat3_%0d", k), 32'(dat3_q[k]), 32'(rom_val(t3_addr[exp_id[k]])));
      end
    end

    // Sparse requesters 1 and 3 with rr_ptr at 0: 1, 3, then wrap back to 1
    @(negedge clk);
    req = 4'b1010;
    #1;
    chk("t4_gnt_a", 32'(bus1.gnt), 32'(4'b0010));
    @(negedge clk);
    #1;
    chk("t4_gnt_b", 32'(bus1.gnt), 32'(4'b1000));
    @(negedge clk);
    #1;
    chk("t4_gnt_c", 32'(bus1.gnt), 32'(4'b0010));
    @(negedge clk);
    req = '0;

    // rr_ptr at 2: requester 0 joins late and waits its turn
    @(negedge clk);
    req = 4'b1110;
    #1;
    chk("t6_gnt_a", 32'(bus1.gnt), 32'(4'b0100));
    @(negedge clk);
    req = 4'b1111;
    #1;
    chk("t6_gnt_b", 32'(bus1.gnt), 32'(4'b1000));
    @(negedge clk);
    #1;
    chk("t6_gnt_c", 32'(bus1.gnt), 32'(4'b0001));
    @(negedge clk);
    #1;
    chk("t6_gnt_d", 32'(bus1.gnt), 32'(4'b0010));
    @(negedge clk);
    req = '0;
    repeat (6) @(negedge clk);

    // Reset with a transfer in flight and rr_ptr away from 0
    set_addr(2, 10'd222);
    req = 4'b1111;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    req   = '0;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t1_quiet%0d", c), 32'(bus1.rsp_valid | bus3.rsp_valid), 32'd0);
    end
    req = 4'b1111;
    #1;
    chk("t1_rr_reset", 32'(bus1.gnt), 32'(4'b0001));
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
